game_round_ctl: RTL

//  Parametrised game-flow controller replacing the fixed ammo digits and test-button scoring in the top.

---
 rtl/game_round_ctl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/game_round_ctl.sv
`default_nettype none
// ============================================================================
// game_round_ctl : sequences a round of ducks (launch/flight/hit/escape/pause)
//                  and keeps BCD score, ammo and ducks-left counters.
//                  Optional macro GAME_ROUND_CTL_BONUS_EN: double points on a
//                  first-shot hit.
// Revision 1.0
// ============================================================================
module game_round_ctl #(
    parameter int AMMO_PER_SHOT_ROUND = 3,
    parameter int DUCKS_PER_ROUND     = 10,
    parameter int SCORE_DIGITS        = 2,
    parameter int HIT_POINTS          = 1,
    parameter int FLIGHT_FRAMES       = 300,
    parameter int PAUSE_FRAMES        = 90
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      new_frame,
    input  logic                      start,
    input  logic                      shot_fired,
    input  logic                      hit,
    output logic                      duck_launch,
    output logic                      duck_kill,
    output logic                      duck_flyaway,
    output logic [3:0]                ammo,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic [7:0]                ducks_left,
    output logic                      game_over
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_FLIGHT    = 3'd2,
        S_FALL      = 3'd3,
        S_ESCAPE    = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    localparam int FRAME_MAX = (FLIGHT_FRAMES > PAUSE_FRAMES) ? FLIGHT_FRAMES : PAUSE_FRAMES;
    localparam int CNT_W     = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1;

    localparam logic [CNT_W-1:0]          FLIGHT_LAST = CNT_W'(FLIGHT_FRAMES - 1);
    localparam logic [CNT_W-1:0]          PAUSE_LAST  = CNT_W'(PAUSE_FRAMES - 1);
    localparam logic [3:0]                AMMO_LOAD   = 4'(AMMO_PER_SHOT_ROUND);
    localparam logic [7:0]                DUCKS_BCD   = {4'(DUCKS_PER_ROUND / 10), 4'(DUCKS_PER_ROUND % 10)};
    localparam logic [4*SCORE_DIGITS-1:0] SCORE_MAX   = {SCORE_DIGITS{4'h9}};

    state_t                    state, state_nxt;
    logic                      start_d;
    logic                      start_rise;
    logic [CNT_W-1:0]          frame_cnt, cnt_nxt;
    logic [3:0]                ammo_nxt;
    logic [3:0]                ammo_after_shot;
    logic [4*SCORE_DIGITS-1:0] score_nxt;
    logic [4*SCORE_DIGITS-1:0] score_sum;
    logic [7:0]                ducks_nxt;
    logic [7:0]                ducks_dec;
    logic                      kill_q, kill_nxt;
    logic                      fly_q, fly_nxt;
    logic [4:0]                add_val;

    assign start_rise      = start & ~start_d;
    assign ammo_after_shot = (shot_fired && ammo != 4'd0) ? ammo - 4'd1 : ammo;
    assign ducks_dec       = (ducks_left == 8'h00) ? 8'h00 :
                             (ducks_left[3:0] == 4'd0) ? {ducks_left[7:4] - 4'd1, 4'd9} :
                                                         {ducks_left[7:4], ducks_left[3:0] - 4'd1};

    // A hit scoring off the first shell of this duck earns the bonus.
    always_comb begin
`ifdef GAME_ROUND_CTL_BONUS_EN
        add_val = (ammo_after_shot == 4'(AMMO_PER_SHOT_ROUND - 1)) ? 5'(2 * HIT_POINTS)
                                                                   : 5'(HIT_POINTS);
`else
        add_val = 5'(HIT_POINTS);
`endif
    end

    // Digit-serial BCD add; any carry out of the top digit pins the score at all 9s.
    always_comb begin
        logic [4:0]                carry;
        logic [4:0]                dsum;
        logic [4*SCORE_DIGITS-1:0] sum;
        carry = add_val;
        dsum  = 5'd0;
        sum   = '0;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            dsum = 5'(score[4*d +: 4]) + carry;
            if (dsum >= 5'd20) begin
                sum[4*d +: 4] = 4'(dsum - 5'd20);
                carry         = 5'd2;
            end else if (dsum >= 5'd10) begin
                sum[4*d +: 4] = 4'(dsum - 5'd10);
                carry         = 5'd1;
            end else begin
                sum[4*d +: 4] = dsum[3:0];
                carry         = 5'd0;
            end
        end
        score_sum = (carry != 5'd0) ? SCORE_MAX : sum;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = frame_cnt;
        ammo_nxt  = ammo;
        score_nxt = score;
        ducks_nxt = ducks_left;
        kill_nxt  = 1'b0;
        fly_nxt   = 1'b0;
        case (state)
            S_IDLE, S_GAME_OVER: begin
                if (start_rise) begin
                    state_nxt = S_LAUNCH;
                    score_nxt = '0;
                    ducks_nxt = DUCKS_BCD;
                end
            end
            S_LAUNCH: begin
                ammo_nxt  = AMMO_LOAD;
                ducks_nxt = ducks_dec;
                cnt_nxt   = '0;
                state_nxt = S_FLIGHT;
            end
            S_FLIGHT: begin
                ammo_nxt = ammo_after_shot;
                if (new_frame)
                    cnt_nxt = frame_cnt + 1'b1;
                // Hit outranks both escape causes; an empty gun escapes one
                // cycle later so a hit trailing the last shell still counts.
                if (hit) begin
                    score_nxt = score_sum;
                    kill_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_FALL;
                end else if (ammo == 4'd0 || (new_frame && frame_cnt == FLIGHT_LAST)) begin
                    fly_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_ESCAPE;
                end
            end
            S_FALL, S_ESCAPE: begin
                if (new_frame) begin
                    if (frame_cnt == PAUSE_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = (ducks_left == 8'h00) ? S_GAME_OVER : S_LAUNCH;
                    end else begin
                        cnt_nxt = frame_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            start_d    <= 1'b0;
            frame_cnt  <= '0;
            ammo       <= 4'd0;
            score      <= '0;
            ducks_left <= DUCKS_BCD;
            kill_q     <= 1'b0;
            fly_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            start_d    <= start;
            frame_cnt  <= cnt_nxt;
            ammo       <= ammo_nxt;
            score      <= score_nxt;
            ducks_left <= ducks_nxt;
            kill_q     <= kill_nxt;
            fly_q      <= fly_nxt;
        end
    end

    assign duck_launch  = (state == S_LAUNCH);
    assign duck_kill    = kill_q;
    assign duck_flyaway = fly_q;
    assign game_over    = (state == S_GAME_OVER);

endmodule
`default_nettype wire
